wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Wishbone classic single-transfer initiator: the master-side counterpart of the user-area Wishbone responder.
- Accepts one command at a time on a valid/ready port, runs exactly one Wishbone cycle, and returns read data plus a status on a valid/ready response port.
- Sits in the user area and is driven by logic-analyzer or bring-up logic. It lets on-chip agents exercise Wishbone slaves without the management core.

Parameters:
- AW, 32, address width of cmd_adr/wbm_adr_o.
- DW, 32, data width of cmd_dat/wbm_dat_o/wbm_dat_i/rsp_dat.
- TIMEOUT, 255, max cycles cyc/stb stay asserted without ack; 0 = no timeout.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  AW  byte address.
- cmd_dat  in  DW  write data.
- cmd_sel  in  DW/8  byte selects.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
- rsp_dat  out  DW  read data; 0 for writes and on failure.
- rsp_timeout  out  1  transfer ended by timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_adr_o  out  AW  Wishbone address.
- wbm_dat_o  out  DW  Wishbone write data.
- wbm_sel_o  out  DW/8  Wishbone byte selects.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_dat_i  in  DW  Wishbone read data.

Behaviour:
- Reset (wb_rst_i high at an edge):
  - State goes to IDLE.
  - All Wishbone outputs, rsp_valid, rsp_dat, rsp_timeout and the timeout counter are cleared to 0.
  - cmd_ready=1 in the cycle after reset.
  - Reset mid-transfer drops cyc/stb at that edge; no response is produced.
- FSM, state register only; all outputs registered except cmd_ready = (state==IDLE).
  - IDLE: on cmd_valid, latch we/adr/dat/sel into wbm_*_o, set cyc=stb=1, clear counter, go BUS.
  - BUS: cyc, stb, we, adr, dat and sel are held stable; counter increments each cycle.
    - On wbm_ack_i: rsp_dat <= (we ? 0 : wbm_dat_i); rsp_timeout <= 0; cyc=stb=0; rsp_valid <= 1; go RESP.
    - Else if TIMEOUT!=0 and counter == TIMEOUT-1: cyc=stb=0; rsp_dat <= 0; rsp_timeout <= 1; rsp_valid <= 1; go RESP.
    - Ack and timeout expiry in the same cycle: ack wins.
  - RESP: rsp_valid, rsp_dat and rsp_timeout are held until rsp_ready; then rsp_valid <= 0 and the FSM goes to IDLE. cmd_ready=0 throughout RESP.
- Latency:
  - Command accepted at edge N → cyc/stb high from N+1.
  - Ack sampled at edge M → cyc/stb low and rsp_valid high from M+1.
  - Minimum command-to-response is 2 cycles.
  - Next command can be accepted one cycle after the response handshake; no back-to-back overlap.
- Ack rules:
  - wbm_ack_i outside BUS is ignored.
  - wbm_dat_i is only sampled in BUS with ack.
  - cmd_valid while not in IDLE has no effect.
- Counter width is $clog2(TIMEOUT+1), minimum 1. Counter saturates and never wraps.
- Invariants: cyc==stb at all times; rsp_valid and cmd_ready never both 1.
- Transactions counted: none. Single outstanding transfer only.

Optional Feature:
- Macro: WB_CMD_MASTER_ERR_EN.
- Defined:
  - Adds input wbm_err_i (1b) and output rsp_err (1b).
  - In BUS, err ends the cycle like ack, with rsp_dat=0, rsp_err=1, rsp_timeout=0.
  - Priority: ack > err > timeout.
  - rsp_err is reset to 0 and cleared on every new command.
- Undefined: neither port exists; behaviour is exactly as above.

Test Plan:
- Read: after reset, cmd read adr=0x3000_0004 sel=0xF; slave acks 3 cycles after stb with 0xDEADBEEF → one cycle of cyc/stb per wait state, wbm_adr_o=0x3000_0004 stable, rsp_valid=1 with rsp_dat=0xDEADBEEF, rsp_timeout=0.
- Write: cmd write adr=0x3000_0000 dat=0x0000_00A5 sel=0x1; slave acks on first cycle → wbm_we_o=1, wbm_dat_o=0xA5, wbm_sel_o=0x1; rsp_valid 2 cycles after accept; rsp_dat=0.
- Timeout: TIMEOUT=4, slave never acks → cyc/stb high exactly 4 cycles; then rsp_valid=1, rsp_timeout=1, rsp_dat=0. Repeat with ack in the 4th cycle → rsp_timeout=0 (ack wins).
- Backpressure: rsp_ready held low 10 cycles → rsp_valid and rsp_dat stable, cmd_ready=0, a new cmd_valid is ignored; after rsp_ready the next command is accepted one cycle later.
- Reset mid-cycle: assert wb_rst_i while in BUS; ack arrives afterwards → outputs 0 at the next edge, no rsp_valid, cmd_ready=1 after reset; a stray ack in IDLE is ignored.
- Err (WB_CMD_MASTER_ERR_EN defined): err asserted in the 2nd BUS cycle → rsp_err=1, rsp_dat=0; err with ack in the same cycle → rsp_err=0 and read data returned.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response out.
// Optional error-acknowledge support is enabled by defining WB_CMD_MASTER_ERR_EN.
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_timeout,
`ifdef WB_CMD_MASTER_ERR_EN
    input  logic            wbm_err_i,
    output logic            rsp_err,
`endif
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i
);

    localparam int SW = DW / 8;
    localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT != 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic            cyc_q,       cyc_d;
    logic            we_q,        we_d;
    logic [AW-1:0]   adr_q,       adr_d;
    logic [DW-1:0]   dat_q,       dat_d;
    logic [SW-1:0]   sel_q,       sel_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_dat_q,   rsp_dat_d;
    logic            rsp_to_q,    rsp_to_d;
`ifdef WB_CMD_MASTER_ERR_EN
    logic            rsp_err_q,   rsp_err_d;
`endif

    // State and registered-output update with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= {AW{1'b0}};
            dat_q       <= {DW{1'b0}};
            sel_q       <= {SW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= {DW{1'b0}};
            rsp_to_q    <= 1'b0;
`ifdef WB_CMD_MASTER_ERR_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_to_q    <= rsp_to_d;
`ifdef WB_CMD_MASTER_ERR_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Next-state and next-output logic; everything holds unless a transition updates it.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_to_d    = rsp_to_q;
`ifdef WB_CMD_MASTER_ERR_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    cyc_d   = 1'b1;
                    cnt_d   = {CW{1'b0}};
`ifdef WB_CMD_MASTER_ERR_EN
                    rsp_err_d = 1'b0;
`endif
                    state_d = ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Saturating so a very long TIMEOUT=0 transfer cannot wrap into a false match.
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1'b1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (wbm_ack_i) begin
                    rsp_dat_d   = we_q ? {DW{1'b0}} : wbm_dat_i;
                    rsp_to_d    = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
`ifdef WB_CMD_MASTER_ERR_EN
                end else if (wbm_err_i) begin
                    rsp_dat_d   = {DW{1'b0}};
                    rsp_to_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
`endif
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    rsp_dat_d   = {DW{1'b0}};
                    rsp_to_d    = 1'b1;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_dat     = rsp_dat_q;
    assign rsp_timeout = rsp_to_q;
`ifdef WB_CMD_MASTER_ERR_EN
    assign rsp_err     = rsp_err_q;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: directed commands push expected responses,
// a monitor pops and compares them on every response handshake.
module tb_wb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef WB_CMD_MASTER_ERR_EN
    localparam int NV = 8;
`else
    localparam int NV = 6;
`endif

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [31:0]   cmd_adr, cmd_dat;
    logic [3:0]    cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0]   rsp_dat;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [31:0]   wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]    wbm_sel_o;
    logic          wbm_err_i;
    logic          rsp_err;

    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_sel     (cmd_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_timeout (rsp_timeout),
`ifdef WB_CMD_MASTER_ERR_EN
        .wbm_err_i   (wbm_err_i),
        .rsp_err     (rsp_err),
`endif
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i)
    );

`ifndef WB_CMD_MASTER_ERR_EN
    assign rsp_err = 1'b0;
`endif

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic [31:0] dat;
        logic        to;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_cyc;
        int          err_cyc;
        logic [31:0] rd;
        int          bp;
        int          exp_cyc;
        logic [31:0] exp_dat;
        logic        exp_to;
        logic        exp_err;
    } vec_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    vec_t vecs[8];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Response monitor: every handshake must match the oldest expected response.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_dat", {32'h0, rsp_dat}, {32'h0, mon_e.dat});
                chk("rsp_timeout", {63'h0, rsp_timeout}, {63'h0, mon_e.to});
                chk("rsp_err", {63'h0, rsp_err}, {63'h0, mon_e.err});
            end
        end
    end

    task automatic run_vec(input int i);
        vec_t v;
        int   ncyc;
        v = vecs[i];
        chk("cmd_ready_idle", {63'h0, cmd_ready}, 64'h1);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        exp_q.push_back('{v.exp_dat, v.exp_to, v.exp_err});
        tick();
        cmd_valid = 1'b0;
        cmd_we    = ~v.we;
        cmd_adr   = 32'hFFFF_FFFF;
        cmd_dat   = ~v.dat;
        cmd_sel   = ~v.sel;
        ncyc = 0;
        for (int k = 0; k < 12; k++) begin
            if (!wbm_cyc_o) break;
            ncyc++;
            chk("stb_eq_cyc", {63'h0, wbm_stb_o}, 64'h1);
            chk("wbm_adr", {32'h0, wbm_adr_o}, {32'h0, v.adr});
            chk("wbm_we", {63'h0, wbm_we_o}, {63'h0, v.we});
            chk("wbm_dat", {32'h0, wbm_dat_o}, {32'h0, v.dat});
            chk("wbm_sel", {60'h0, wbm_sel_o}, {60'h0, v.sel});
            wbm_ack_i = (ncyc == v.ack_cyc);
            wbm_err_i = (ncyc == v.err_cyc);
            wbm_dat_i = wbm_ack_i ? v.rd : 32'h5A5A_5A5A;
            tick();
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        chk("bus_cycles", 64'(ncyc), 64'(v.exp_cyc));
        chk("stb_low", {63'h0, wbm_stb_o}, 64'h0);
        chk("rsp_valid_up", {63'h0, rsp_valid}, 64'h1);
        chk("cmd_ready_resp", {63'h0, cmd_ready}, 64'h0);
        for (int k = 0; k < v.bp; k++) begin
            cmd_valid = 1'b1;
            cmd_adr   = 32'h4000_0000 + 32'(k);
            chk("bp_rsp_valid", {63'h0, rsp_valid}, 64'h1);
            chk("bp_rsp_dat", {32'h0, rsp_dat}, {32'h0, v.exp_dat});
            chk("bp_cmd_ready", {63'h0, cmd_ready}, 64'h0);
            chk("bp_cyc", {63'h0, wbm_cyc_o}, 64'h0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_down", {63'h0, rsp_valid}, 64'h0);
        chk("cmd_ready_back", {63'h0, cmd_ready}, 64'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //               we    adr            dat            sel    ack err rd             bp  cyc exp_dat       to    err
        vecs[0] = '{1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF, 3, 0, 32'hDEAD_BEEF, 0,  3, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h3000_0000, 32'h0000_00A5, 4'h1, 1, 0, 32'h7777_7777, 0,  1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, 0, 0, 32'h0000_0000, 0,  4, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h3000_000C, 32'h0000_0000, 4'hF, 4, 0, 32'h1234_5678, 0,  4, 32'h1234_5678, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h3000_0020, 32'h0000_0000, 4'h3, 2, 0, 32'hCAFE_F00D, 10, 2, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h3000_0024, 32'h1234_5678, 4'hC, 4, 0, 32'hFFFF_FFFF, 0,  4, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h3000_0028, 32'h0000_0000, 4'hF, 0, 2, 32'h0000_0000, 0,  2, 32'h0000_0000, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 32'h3000_002C, 32'h0000_0000, 4'hF, 2, 2, 32'h0BAD_F00D, 0,  2, 32'h0BAD_F00D, 1'b0, 1'b0};

        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'h0;
        tick();
        tick();
        wb_rst_i = 1'b0;
        chk("rst_cyc", {63'h0, wbm_cyc_o}, 64'h0);
        chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("rst_rsp_dat", {32'h0, rsp_dat}, 64'h0);
        chk("rst_adr", {32'h0, wbm_adr_o}, 64'h0);
        chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);

        for (int i = 0; i < NV; i++) begin
            run_vec(i);
        end

        // Reset in the middle of a bus cycle, with ack arriving during and after reset.
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0010;
        cmd_dat   = 32'h0000_0033;
        cmd_sel   = 4'hF;
        tick();
        cmd_valid = 1'b0;
        chk("mid_cyc_up", {63'h0, wbm_cyc_o}, 64'h1);
        tick();
        wb_rst_i  = 1'b1;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1111_1111;
        rsp_ready = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        chk("mid_cyc", {63'h0, wbm_cyc_o}, 64'h0);
        chk("mid_stb", {63'h0, wbm_stb_o}, 64'h0);
        chk("mid_we", {63'h0, wbm_we_o}, 64'h0);
        chk("mid_adr", {32'h0, wbm_adr_o}, 64'h0);
        chk("mid_dat", {32'h0, wbm_dat_o}, 64'h0);
        chk("mid_sel", {60'h0, wbm_sel_o}, 64'h0);
        chk("mid_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("mid_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        tick();
        chk("stray_ack_cyc", {63'h0, wbm_cyc_o}, 64'h0);
        chk("stray_ack_rsp", {63'h0, rsp_valid}, 64'h0);
        tick();
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b0;
        chk("stray_ack_rsp2", {63'h0, rsp_valid}, 64'h0);
        chk("stray_ack_rdy", {63'h0, cmd_ready}, 64'h1);

        run_vec(1);
        run_vec(0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
